// File: rtl/src_msg_packer_pkg.sv
// Shared defines for the per-source message packers and the parent that
// replicates them ahead of the USB slave-FIFO engine.
package src_msg_packer_pkg;

  localparam int NUM_SOURCES   = 4;
  localparam int MSG_GAP_CLKS  = 64;
  localparam int MSG_MAX_WORDS = 255;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DISCARD = 2'd2
  } pk_state_e;

  typedef struct packed {
    logic       parity;
    logic [7:0] len;
  } len_entry_t;

  // A trailing pending byte adds one padded word and makes the byte count odd.
  function automatic len_entry_t make_entry(input logic [7:0] words, input logic pend);
    len_entry_t e;
    e.parity = pend;
    e.len    = words + {7'd0, pend};
    return e;
  endfunction

endpackage

// File: rtl/src_msg_packer_sa_sync_fifo.sv
// Show-ahead synchronous FIFO: q_o presents the head entry whenever the FIFO
// is non-empty and reads zero when empty.
module sa_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wd_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] q_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [AW:0]      free_o
);

  localparam logic [AW:0] DEPTH = (AW+1)'(1'b1) << AW;

  logic [WIDTH-1:0] mem_q [2**AW];
  logic [AW-1:0]    wp_q, rp_q;
  logic [AW:0]      cnt_q;
  logic             do_wr_s, do_rd_s;

  assign empty_o = (cnt_q == {(AW+1){1'b0}});
  assign full_o  = (cnt_q == DEPTH);
  assign free_o  = DEPTH - cnt_q;
  assign do_wr_s = wr_i && !full_o;
  assign do_rd_s = rd_i && !empty_o;
  assign q_o     = empty_o ? {WIDTH{1'b0}} : mem_q[rp_q];

  // Storage array; contents are don't-care while not covered by the count.
  always_ff @(posedge CLK) begin
    if (do_wr_s) mem_q[wp_q] <= wd_i;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wp_q  <= {AW{1'b0}};
      rp_q  <= {AW{1'b0}};
      cnt_q <= {(AW+1){1'b0}};
    end else begin
      if (do_wr_s) wp_q <= wp_q + AW'(1'b1);
      if (do_rd_s) rp_q <= rp_q + AW'(1'b1);
      case ({do_wr_s, do_rd_s})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1'b1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1'b1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/src_msg_packer.sv
// Frames one source's byte stream into gap-delimited messages, packs bytes
// into 16-bit words and tracks per-message length/parity for the USB engine.
module src_msg_packer
  import src_msg_packer_pkg::*;
#(
  parameter int FIFO_AW   = 9,
  parameter int LQ_AW     = 2,
  parameter int GAP_CLKS  = MSG_GAP_CLKS,
  parameter int MAX_WORDS = MSG_MAX_WORDS
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  input  logic        RD_REQ,
  input  logic        MSG_START,
  output logic [15:0] FIFO_Q,
  output logic        GOT_FULL_MSG,
  output logic [7:0]  MSG_LEN,
  output logic        PARITY,
  output logic        DROP,
  output logic [7:0]  DROP_CNT,
  output logic        PROTO_ERR
);

  localparam int               GW       = $clog2(GAP_CLKS);
  localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_CLKS - 1);
  localparam logic [7:0]       MAXW_8   = 8'(MAX_WORDS);
  localparam logic [FIFO_AW:0] MAXW_F   = (FIFO_AW+1)'(MAX_WORDS);
  localparam logic [LQ_AW:0]   LQ_ONE   = (LQ_AW+1)'(1'b1);

  pk_state_e     state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          pend_q, pend_d;
  logic [7:0]    pbyte_q, pbyte_d;
  logic [7:0]    wcnt_q, wcnt_d;
  logic          wvld_q, wvld_d;
  logic [15:0]   wword_q, wword_d;
  logic          ppush_q, ppush_d;
  logic [7:0]    rdcnt_q, rdcnt_d;
  logic          drop_q, drop_d;
  logic [7:0]    dcnt_q, dcnt_d;
  logic          perr_q, perr_d;

  logic             dwr_s, d_empty_s, d_full_s;
  logic [15:0]      dwd_s, d_q_s;
  logic [FIFO_AW:0] d_free_s;
  logic             lpush_s, lpop_s, l_empty_s, l_full_s, admit_s;
  len_entry_t       lwd_s, lhead_s;
  logic [LQ_AW:0]   l_free_s;

  // A max-length close leaves its last word and length push in flight for one
  // cycle, so admission discounts them to guarantee the next message fits.
  assign admit_s = !d_full_s && ((d_free_s > MAXW_F) || ((d_free_s == MAXW_F) && !wvld_q))
                && !l_full_s && ((l_free_s > LQ_ONE) || !ppush_q);

  // Message framing FSM, byte packing and drop accounting.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pend_d  = pend_q;
    pbyte_d = pbyte_q;
    wcnt_d  = wcnt_q;
    wvld_d  = 1'b0;
    wword_d = wword_q;
    ppush_d = 1'b0;
    drop_d  = 1'b0;
    dcnt_d  = dcnt_q;
    dwr_s   = wvld_q;
    dwd_s   = wword_q;
    lpush_s = ppush_q;
    lwd_s   = make_entry(MAXW_8, 1'b0);
    case (state_q)
      ST_IDLE: begin
        gap_d = {GW{1'b0}};
        if (!RX_VALID) begin
          state_d = ST_IDLE;
        end else if (admit_s) begin
          state_d = ST_COLLECT;
          pend_d  = 1'b1;
          pbyte_d = RX_DATA;
          wcnt_d  = 8'd0;
        end else begin
          state_d = ST_DISCARD;
          drop_d  = 1'b1;
          if (dcnt_q != 8'hFF) dcnt_d = dcnt_q + 8'd1;
          else                 dcnt_d = dcnt_q;
        end
      end
      ST_COLLECT: begin
        if (RX_VALID) begin
          gap_d = {GW{1'b0}};
          if (!pend_q) begin
            pend_d  = 1'b1;
            pbyte_d = RX_DATA;
          end else begin
            pend_d  = 1'b0;
            wvld_d  = 1'b1;
            wword_d = {RX_DATA, pbyte_q};
            wcnt_d  = wcnt_q + 8'd1;
            if (wcnt_q == MAXW_8 - 8'd1) begin
              ppush_d = 1'b1;
              state_d = ST_IDLE;
            end else begin
              ppush_d = 1'b0;
            end
          end
        end else if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
          gap_d   = {GW{1'b0}};
          pend_d  = 1'b0;
          lpush_s = 1'b1;
          lwd_s   = make_entry(wcnt_q, pend_q);
          if (pend_q) begin
            dwr_s = 1'b1;
            dwd_s = {8'h00, pbyte_q};
          end else begin
            dwr_s = wvld_q;
          end
        end else begin
          gap_d = gap_q + GW'(1'b1);
        end
      end
      ST_DISCARD: begin
        if (RX_VALID) begin
          gap_d = {GW{1'b0}};
        end else if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
          gap_d   = {GW{1'b0}};
        end else begin
          gap_d = gap_q + GW'(1'b1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read-side word counter, length-queue retirement and protocol checking.
  always_comb begin
    rdcnt_d = rdcnt_q;
    lpop_s  = 1'b0;
    if (RD_REQ && !l_empty_s) begin
      if (rdcnt_q == lhead_s.len - 8'd1) begin
        lpop_s  = 1'b1;
        rdcnt_d = 8'd0;
      end else begin
        rdcnt_d = rdcnt_q + 8'd1;
      end
    end else begin
      rdcnt_d = rdcnt_q;
    end
    perr_d = perr_q | (RD_REQ & (d_empty_s | l_empty_s))
                    | (MSG_START & ((rdcnt_q != 8'd0) | l_empty_s));
  end

  // State registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      gap_q   <= {GW{1'b0}};
      pend_q  <= 1'b0;
      pbyte_q <= 8'd0;
      wcnt_q  <= 8'd0;
      wvld_q  <= 1'b0;
      wword_q <= 16'd0;
      ppush_q <= 1'b0;
      rdcnt_q <= 8'd0;
      drop_q  <= 1'b0;
      dcnt_q  <= 8'd0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      pbyte_q <= pbyte_d;
      wcnt_q  <= wcnt_d;
      wvld_q  <= wvld_d;
      wword_q <= wword_d;
      ppush_q <= ppush_d;
      rdcnt_q <= rdcnt_d;
      drop_q  <= drop_d;
      dcnt_q  <= dcnt_d;
      perr_q  <= perr_d;
    end
  end

  sa_sync_fifo #(.WIDTH(16), .AW(FIFO_AW)) u_data_fifo (
    .CLK(CLK), .RST(RST),
    .wr_i(dwr_s), .wd_i(dwd_s), .rd_i(RD_REQ),
    .q_o(d_q_s), .empty_o(d_empty_s), .full_o(d_full_s), .free_o(d_free_s)
  );

  sa_sync_fifo #(.WIDTH(9), .AW(LQ_AW)) u_len_fifo (
    .CLK(CLK), .RST(RST),
    .wr_i(lpush_s), .wd_i(lwd_s), .rd_i(lpop_s),
    .q_o(lhead_s), .empty_o(l_empty_s), .full_o(l_full_s), .free_o(l_free_s)
  );

  assign FIFO_Q       = d_q_s;
  assign GOT_FULL_MSG = !l_empty_s;
  assign MSG_LEN      = lhead_s.len;
  assign PARITY       = lhead_s.parity;
  assign DROP         = drop_q;
  assign DROP_CNT     = dcnt_q;
  assign PROTO_ERR    = perr_q;

endmodule
